// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants plus the dump engine's state encoding and output payload.
package mips_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_FETCH = 2'd1,
    DS_SEND  = 2'd2,
    DS_DONE  = 2'd3
  } dump_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;
  } dump_word_t;

endpackage

// File: rtl/mips_reg_dump_if.sv
// Control, register-file read port and valid/ready stream of the register dump engine.
interface mips_reg_dump_if;
  import mips_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output start, first_reg, last_reg, rd_data, out_ready,
    input  busy, done, rd_addr, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  start, first_reg, last_reg, rd_data, out_ready,
    output busy, done, rd_addr, out_valid, out_data, out_index, out_last
  );

endinterface

// File: rtl/mips_reg_dump.sv
// Walks a (possibly wrapping) register range through one read port and streams each word
// with its index over valid/ready.
module mips_reg_dump
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mips_reg_dump_if.slave  dump_if
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  dump_word_t        word_q, word_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              hs;

  assign hs = valid_q & dump_if.out_ready;

  // Next-state, index counter and output holding register
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    word_d  = word_q;
    case (state_q)
      DS_IDLE: begin
        if (dump_if.start) begin
          cur_d   = dump_if.first_reg;
          last_d  = dump_if.last_reg;
          state_d = DS_FETCH;
        end
      end
      DS_FETCH: begin
        word_d.data  = dump_if.rd_data;
        word_d.index = cur_q;
        word_d.last  = (cur_q == last_q);
        state_d      = DS_SEND;
      end
      DS_SEND: begin
        if (hs) begin
          if (word_q.last) begin
            state_d = DS_DONE;
          end else begin
            // ADDR_W-bit add makes the range wrap past the top register for free
            cur_d   = cur_q + ADDR_W'(1);
            state_d = DS_FETCH;
          end
        end
      end
      DS_DONE: state_d = DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    valid_d = (state_d == DS_SEND);
    done_d  = (state_d == DS_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DS_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // rd_addr and busy decode straight from state so the external read mux switches in time
  assign dump_if.busy      = (state_q != DS_IDLE);
  assign dump_if.rd_addr   = (state_q == DS_FETCH) ? cur_q : '0;
  assign dump_if.done      = done_q;
  assign dump_if.out_valid = valid_q;
  assign dump_if.out_data  = word_q.data;
  assign dump_if.out_index = word_q.index;
  assign dump_if.out_last  = word_q.last;

endmodule

// File: tb/tb_mips_reg_dump.sv
// Directed bench for mips_reg_dump with a behavioural 8x32 register file on the read port.
module tb_mips_reg_dump;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;

  mips_reg_dump_if u_if ();

  mips_reg_dump u_dut (
    .clk     (clk),
    .rst     (rst),
    .dump_if (u_if)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [8];
  logic        wr_en = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic [31:0] wr_val = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 32'(i * 3);
    end else if (wr_en) begin
      regs[wr_idx] <= wr_val;
    end
  end

  assign u_if.rd_data = regs[u_if.rd_addr];

  int checks = 0;
  int errors = 0;

  logic [31:0] got_data [$];
  logic [2:0]  got_idx  [$];
  logic        got_last [$];
  int          done_cnt, done_cyc, idle_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_dump(input logic [2:0] f, input logic [2:0] l, input int stall_word,
                          input int stall_len, input bit poke, input int hz_idx,
                          input logic [31:0] hz_val);
    int cyc, word_no, stall_left, hz;
    bit have_prev;
    logic [31:0] p_data;
    logic [2:0]  p_idx;
    logic        p_last;
    got_data.delete(); got_idx.delete(); got_last.delete();
    done_cnt = 0; done_cyc = -1; idle_cyc = -1; hz = hz_idx;
    u_if.first_reg = f; u_if.last_reg = l; u_if.out_ready = 1'b1; u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    cyc = 1;
    chk("busy_c1", 32'(u_if.busy), 32'd1);
    chk("valid_c1", 32'(u_if.out_valid), 32'd0);
    chk("rdaddr_c1", 32'(u_if.rd_addr), 32'(f));
    word_no = 0; stall_left = 0; have_prev = 0;
    p_data = '0; p_idx = '0; p_last = 1'b0;
    while (cyc < 200) begin
      if (u_if.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!u_if.busy) begin
        idle_cyc = cyc;
        break;
      end
      wr_en = 1'b0;
      if (hz > 0 && u_if.rd_addr == 3'(hz)) begin
        wr_en = 1'b1; wr_idx = 3'(hz); wr_val = hz_val; hz = -1;
      end
      if (u_if.out_valid) begin
        if (have_prev) begin
          chk("hold_data", u_if.out_data, p_data);
          chk("hold_index", 32'(u_if.out_index), 32'(p_idx));
          chk("hold_last", 32'(u_if.out_last), 32'(p_last));
        end else if (word_no == stall_word) begin
          stall_left = stall_len;
        end
        if (stall_left > 0) begin
          u_if.out_ready = 1'b0;
          stall_left--;
          have_prev = 1;
          p_data = u_if.out_data; p_idx = u_if.out_index; p_last = u_if.out_last;
        end else begin
          u_if.out_ready = 1'b1;
          got_data.push_back(u_if.out_data);
          got_idx.push_back(u_if.out_index);
          got_last.push_back(u_if.out_last);
          word_no++;
          have_prev = 0;
        end
      end else begin
        if (have_prev) chk("valid_hold", 32'(u_if.out_valid), 32'd1);
        have_prev = 0;
        u_if.out_ready = 1'b1;
      end
      u_if.start = poke;
      if (poke) begin
        u_if.first_reg = 3'd5; u_if.last_reg = 3'd5;
      end
      tick();
      cyc++;
    end
    u_if.start = 1'b0; wr_en = 1'b0; u_if.out_ready = 1'b1;
    chk("dump_timeout", 32'(idle_cyc >= 0), 32'd1);
  endtask

  task automatic check_words(input logic [2:0] f, input int n);
    logic [2:0] ix;
    chk("word_count", 32'(got_data.size()), 32'(n));
    for (int k = 0; k < n && k < got_data.size(); k++) begin
      ix = f + 3'(k);
      chk("word_index", 32'(got_idx[k]), 32'(ix));
      chk("word_data", got_data[k], regs[ix]);
      chk("word_last", 32'(got_last[k]), 32'(k == n - 1));
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    u_if.start = 1'b0; u_if.first_reg = '0; u_if.last_reg = '0; u_if.out_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_done", 32'(u_if.done), 32'd0);
    chk("rst_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_rdaddr", 32'(u_if.rd_addr), 32'd0);
    chk("rst_data", u_if.out_data, 32'd0);
    chk("rst_index", 32'(u_if.out_index), 32'd0);
    chk("rst_last", 32'(u_if.out_last), 32'd0);
    rst = 1'b0;
    tick();

    // Full dump 0..7, r[i] = 3i
    run_dump(3'd0, 3'd7, -1, 0, 1'b0, -1, '0);
    check_words(3'd0, 8);
    chk("full_word7", got_data.size() == 8 ? got_data[7] : 32'hx, 32'd21);
    chk("full_done_cyc", 32'(done_cyc), 32'd17);
    chk("full_idle_cyc", 32'(idle_cyc), 32'd18);
    chk("full_done_cnt", 32'(done_cnt), 32'd1);
    tick();

    // Wrap 6..1 -> 6,7,0,1
    run_dump(3'd6, 3'd1, -1, 0, 1'b0, -1, '0);
    check_words(3'd6, 4);
    chk("wrap_idx2", got_idx.size() == 4 ? 32'(got_idx[2]) : 32'hx, 32'd0);
    chk("wrap_done_cyc", 32'(done_cyc), 32'd9);
    chk("wrap_done_cnt", 32'(done_cnt), 32'd1);
    tick();

    // Backpressure: 5 stall cycles on the second word
    run_dump(3'd0, 3'd3, 1, 5, 1'b0, -1, '0);
    check_words(3'd0, 4);
    chk("stall_done_cyc", 32'(done_cyc), 32'd14);
    chk("stall_done_cnt", 32'(done_cnt), 32'd1);
    tick();

    // Hazard: write r[2]=3 on the edge that closes FETCH of 2
    run_dump(3'd0, 3'd3, -1, 0, 1'b0, 2, 32'h3);
    chk("hz_count", 32'(got_data.size()), 32'd4);
    chk("hz_old_r2", got_data.size() == 4 ? got_data[2] : 32'hx, 32'd6);
    chk("hz_r3", got_data.size() == 4 ? got_data[3] : 32'hx, 32'd9);
    chk("hz_done_cnt", 32'(done_cnt), 32'd1);
    tick();
    run_dump(3'd2, 3'd2, -1, 0, 1'b0, -1, '0);
    chk("hz2_count", 32'(got_data.size()), 32'd1);
    chk("hz2_new_r2", got_data.size() == 1 ? got_data[0] : 32'hx, 32'h3);
    chk("hz2_last", got_last.size() == 1 ? 32'(got_last[0]) : 32'hx, 32'd1);
    chk("hz2_done_cyc", 32'(done_cyc), 32'd3);
    tick();

    // start pulsed through FETCH, SEND and DONE is ignored
    run_dump(3'd1, 3'd3, -1, 0, 1'b1, -1, '0);
    check_words(3'd1, 3);
    chk("poke_done_cyc", 32'(done_cyc), 32'd7);
    chk("poke_done_cnt", 32'(done_cnt), 32'd1);
    tick();
    chk("poke_stays_idle", 32'(u_if.busy), 32'd0);

    // Async reset mid-SEND of the 4th word
    u_if.first_reg = 3'd0; u_if.last_reg = 3'd7; u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (u_if.out_valid && u_if.out_index == 3'd3) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("rst_find_w4", 32'(found), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(u_if.busy), 32'd0);
    chk("mid_rst_valid", 32'(u_if.out_valid), 32'd0);
    chk("mid_rst_rdaddr", 32'(u_if.rd_addr), 32'd0);
    chk("mid_rst_data", u_if.out_data, 32'd0);
    chk("mid_rst_index", 32'(u_if.out_index), 32'd0);
    chk("mid_rst_last", 32'(u_if.out_last), 32'd0);
    chk("mid_rst_done", 32'(u_if.done), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_done", 32'(u_if.done), 32'd0);
    chk("post_rst_busy", 32'(u_if.busy), 32'd0);

    run_dump(3'd3, 3'd5, -1, 0, 1'b0, -1, '0);
    check_words(3'd3, 3);
    chk("restart_done_cyc", 32'(done_cyc), 32'd7);
    chk("restart_done_cnt", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_reg_dump.md
# mips_reg_dump

Hardware register-file dump engine: the read-side counterpart to testbench-driven register loading. On a start pulse it walks a contiguous (optionally wrapping) range of the 8×32 MIPS register file through one read port, one address at a time. Each captured word is streamed out over a valid/ready interface with its register index. It sits beside `mips_registers`, muxed onto the `read_reg_1` / `read_data_1` pair while `busy` is high. It replaces `$writememb`-style dumps for on-chip debug and self-checking benches.

## Interface
- `NUM_REGS`, 8, number of architectural registers.
- `ADDR_W`, 3, register index width.
- `DATA_W`, 32, register word width.

- `clk`  in  1  single clock, rising-edge active.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `first_reg`  in  ADDR_W  first index dumped; sampled with `start`.
- `last_reg`  in  ADDR_W  last index dumped; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE exits.
- `done`  out  1  one-cycle pulse after the final word handshakes.
- `rd_addr`  out  ADDR_W  to the register-file read address; 0 when not in FETCH.
- `rd_data`  in  DATA_W  from the register-file read data; combinational on `rd_addr`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_W  captured register value.
- `out_index`  out  ADDR_W  index of `out_data`.
- `out_last`  out  1  high with the final word of the range.

## Operation
- The FSM has four states: IDLE, FETCH, SEND, DONE. Its encoding comes from the package.
- **IDLE**
  - On `start`: `cur` ← `first_reg`, `last_q` ← `last_reg`, go to FETCH.
  - Without `start`: stay in IDLE.
- **FETCH** (exactly one cycle)
  - `rd_addr` = `cur`.
  - At the clock edge: `out_data` ← `rd_data`, `out_index` ← `cur`, `out_last` ← (`cur` == `last_q`).
  - Go to SEND.
- **SEND**
  - `out_valid` = 1. `out_data`, `out_index` and `out_last` hold stable until the handshake (`out_valid` && `out_ready`).
  - On handshake with `out_last`: go to DONE.
  - On handshake otherwise: `cur` ← `cur` + 1 mod `NUM_REGS`, then go to FETCH.
- **DONE**: `done` = 1 for one cycle, then go to IDLE.
- **Range and wrap-around**
  - Words dumped = ((`last_reg` − `first_reg`) mod 8) + 1.
  - `first_reg` == `last_reg` dumps exactly one word.
  - `first_reg` = 6, `last_reg` = 1 dumps indices 6, 7, 0, 1.
  - `cur` increments in ADDR_W-bit arithmetic, so wrap is implicit.
- **Simultaneous events**
  - `start` in any state other than IDLE is ignored.
  - `start` in the DONE cycle is ignored.
- **Register-file writes during a dump**
  - A write to index k at the same edge that closes FETCH of k: the captured value is the pre-write value.
  - Writes to indices not yet fetched are reflected in the dump.
- **Reset**
  - `rst` forces IDLE immediately, at any point, including mid-dump.
  - Reset values: `cur` = 0, `last_q` = 0, `out_data` = 0, `out_index` = 0, `out_last` = 0.
  - Reset output values: `busy` = 0, `done` = 0, `out_valid` = 0, `rd_addr` = 0.
  - A partial dump is abandoned. No `done` pulse is generated.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: FETCH, `busy` = 1.
- Cycle 2: `out_valid` = 1 with the first word.
- Latency from `start` to first `out_valid` is 2 cycles.
- With `out_ready` held high, one word is emitted every 2 cycles. Throughput is DATA_W bits per 2 cycles.
- `done` is asserted in the cycle after the last handshake. `busy` drops in the cycle after `done`.
- Full 8-register dump with `out_ready` = 1: `start` at cycle 0, `done` at cycle 17, `busy` = 0 at cycle 18.
- `out_valid` never deasserts without a handshake, except on reset.
- All outputs are registered, except `rd_addr` and `busy`, which decode from state.

## Structure
- Shared package `mips_pkg` holds:
  - `NUM_REGS`, `ADDR_W`, `DATA_W` constants, shared with `mips_registers`.
  - The `dump_state_t` enum (IDLE, FETCH, SEND, DONE).
- No sub-module is required. The FSM, index counter and output holding register live in one module.
- The read-port mux between the CPU and the dumper is outside this block and is selected by `busy`.

## Test plan
- Registers preloaded with r[i] = i×3; `start`, `first_reg` = 0, `last_reg` = 7, `out_ready` = 1.
  - Response: 8 words 0, 3, …, 21, with `out_index` 0..7 and `out_last` only on index 7.
  - `done` at cycle 17.
- Wrap: `first_reg` = 6, `last_reg` = 1.
  - Response: indices 6, 7, 0, 1 in order, then a single `done` pulse.
- Backpressure: `out_ready` low for 5 cycles in the second SEND.
  - Response: `out_valid`, `out_data`, `out_index` and `out_last` stable throughout. No word is dropped or duplicated.
- Hazard: write r[2] = 32'h3, timed at the edge closing FETCH of 2.
  - Response: the dump shows the old r[2].
  - A second dump shows 32'h3.
- `rst` asserted mid-SEND on the 4th word.
  - Response: outputs reach their reset values without waiting for a clock edge. No `done` pulse.
  - A new `start` after reset restarts cleanly from `first_reg`.
- `start` pulsed in FETCH, SEND and DONE.
  - Response: ignored. Word count and indices unchanged.
